// File: rtl/mnacidpro_seq.sv
// Protocol sequencer for the nucleic-acid purification chip: runs SIZE samples through
// bead load, lysis, wash, elute and collect, driving the ctrl valves and peristaltic pump.
module mnacidpro_seq #(
    parameter int SIZE     = 7,
    parameter int STEP_W   = 16,
    parameter int PUMP_DIV = 4,
    localparam int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] step_len,
    output logic              lysis_ctrl,
    output logic              wash_ctrl,
    output logic              elute_ctrl,
    output logic              dead_end_ctrl,
    output logic              vertical_ctrl,
    output logic              horiz_ctrl,
    output logic              waste_ctrl,
    output logic              bead_ctrl,
    output logic              loop_exit_ctrl,
    output logic              bead_trap_ctrl,
    output logic              collect_ctrl,
    output logic [2:0]        pump,
    output logic [IDX_W-1:0]  collect_idx,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [DIV_W-1:0]  LAST_DIV = DIV_W'(PUMP_DIV - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SIZE - 1);
    localparam logic [STEP_W-1:0] ONE      = STEP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_BEAD_LOAD, S_LYSIS, S_WASH, S_ELUTE, S_COLLECT, S_DONE
    } state_t;

    typedef struct packed {
        logic lysis, wash, elute, dead_end, vertical, horiz;
        logic waste, bead, loop_exit, bead_trap, collect;
    } valves_t;

    state_t            state, state_nxt;
    logic [STEP_W-1:0] n_len, n_len_nxt, cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [1:0]        phase, phase_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    logic              aborted_nxt;
    valves_t           closed_q;

    // Set of valves opened (1 = open) in each state.
    function automatic valves_t open_set(state_t s);
        valves_t v;
        v = '0;
        case (s)
            S_BEAD_LOAD: begin v.bead = 1'b1; v.bead_trap = 1'b1; v.waste = 1'b1; end
            S_LYSIS:     begin v.lysis = 1'b1; v.horiz = 1'b1; v.dead_end = 1'b1; end
            S_WASH:      begin
                v.wash = 1'b1; v.vertical = 1'b1; v.bead_trap = 1'b1; v.waste = 1'b1;
            end
            S_ELUTE:     begin v.elute = 1'b1; v.vertical = 1'b1; v.loop_exit = 1'b1; end
            S_COLLECT:   begin v.loop_exit = 1'b1; v.collect = 1'b1; end
            default:     v = '0;
        endcase
        return v;
    endfunction

    function automatic logic pumped(state_t s);
        return s inside {S_BEAD_LOAD, S_LYSIS, S_WASH, S_ELUTE};
    endfunction

    function automatic logic [2:0] pump_pattern(logic [1:0] p);
        case (p)
            2'd0:    return 3'b011;
            2'd1:    return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_nxt   = state;
        n_len_nxt   = n_len;
        cnt_nxt     = cnt;
        idx_nxt     = collect_idx;
        phase_nxt   = phase;
        div_nxt     = div;
        aborted_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    n_len_nxt = (step_len == '0) ? ONE : step_len;
                    cnt_nxt   = n_len_nxt - ONE;
                    idx_nxt   = '0;
                    phase_nxt = '0;
                    div_nxt   = '0;
                    state_nxt = S_BEAD_LOAD;
                end
            end
            S_DONE: begin
                state_nxt   = S_IDLE;
                aborted_nxt = abort;
            end
            S_BEAD_LOAD, S_LYSIS, S_WASH, S_ELUTE, S_COLLECT: begin
                // Abort outranks a step end landing on the same cycle.
                if (abort) begin
                    state_nxt   = S_IDLE;
                    aborted_nxt = 1'b1;
                end else if (cnt == '0) begin
                    cnt_nxt   = n_len - ONE;
                    phase_nxt = '0;
                    div_nxt   = '0;
                    case (state)
                        S_BEAD_LOAD: state_nxt = S_LYSIS;
                        S_LYSIS:     state_nxt = S_WASH;
                        S_WASH:      state_nxt = S_ELUTE;
                        S_ELUTE:     state_nxt = S_COLLECT;
                        default: begin
                            if (collect_idx < LAST_IDX) begin
                                idx_nxt   = collect_idx + IDX_W'(1);
                                state_nxt = S_BEAD_LOAD;
                            end else begin
                                state_nxt = S_DONE;
                            end
                        end
                    endcase
                end else begin
                    cnt_nxt = cnt - ONE;
                    if (div == LAST_DIV) begin
                        div_nxt   = '0;
                        phase_nxt = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                    end else begin
                        div_nxt = div + DIV_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode, so they change together with state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state       <= S_IDLE;
            n_len       <= ONE;
            cnt         <= '0;
            collect_idx <= '0;
            phase       <= '0;
            div         <= '0;
            closed_q    <= '1;
            pump        <= 3'b111;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state       <= state_nxt;
            n_len       <= n_len_nxt;
            cnt         <= cnt_nxt;
            collect_idx <= idx_nxt;
            phase       <= phase_nxt;
            div         <= div_nxt;
            closed_q    <= valves_t'(~open_set(state_nxt));
            pump        <= pumped(state_nxt) ? pump_pattern(phase_nxt) : 3'b111;
            busy        <= (state_nxt != S_IDLE);
            done        <= (state_nxt == S_DONE);
            aborted     <= aborted_nxt;
        end
    end

    assign lysis_ctrl     = closed_q.lysis;
    assign wash_ctrl      = closed_q.wash;
    assign elute_ctrl     = closed_q.elute;
    assign dead_end_ctrl  = closed_q.dead_end;
    assign vertical_ctrl  = closed_q.vertical;
    assign horiz_ctrl     = closed_q.horiz;
    assign waste_ctrl     = closed_q.waste;
    assign bead_ctrl      = closed_q.bead;
    assign loop_exit_ctrl = closed_q.loop_exit;
    assign bead_trap_ctrl = closed_q.bead_trap;
    assign collect_ctrl   = closed_q.collect;

endmodule
